// File: rtl/mini_cpu_control.sv
// Instruction sequencer for the mini CPU: latches one instruction per 'enviar' press and
// drives the register-file RAM through read, execute and write-back (or a full clear).
module mini_cpu_control #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int IMM_W       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enviar,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic [ADDR_W-1:0] dest,
    input  logic              sinalImm,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    output logic              busy,
    output logic              done,
    output logic              show_lcd,
    output logic [DATA_W-1:0] valorFinal,
    output logic [2:0]        dbg_state_o
);

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    state_t              state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                prev_q;
    logic                pulse;
    logic [2:0]          ir_op_q;
    logic [ADDR_W-1:0]   ir_dest_q;
    logic                ir_sinal_q;
    logic [IMM_W-1:0]    ir_imm_q;
    logic [ADDR_W-1:0]   clr_idx_q;
    logic [ADDR_W-1:0]   raddr1_q, raddr2_q, waddr_q;
    logic [DATA_W-1:0]   wdata_q, val_q;
    logic                we_q, done_q, lcd_q;
    logic [DATA_W-1:0]   immv_d, alu_d;

    // Handshake: a press is accepted only while busy is low (IDLE); presses seen while
    // busy are dropped, never queued. done pulses once per accepted press.

    // Flops reset to 1 so a button held through reset needs release + new press to fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], enviar};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        immv_d = {{(DATA_W-IMM_W){1'b0}}, ir_imm_q};
        if (ir_sinal_q) begin
            immv_d = '0 - immv_d;
        end
        alu_d = '0;
        case (ir_op_q)
            OP_LOAD:    alu_d = immv_d;
            OP_ADD:     alu_d = rf_rdata1 + rf_rdata2;
            OP_ADDI:    alu_d = rf_rdata1 + immv_d;
            OP_SUB:     alu_d = rf_rdata1 - rf_rdata2;
            OP_SUBI:    alu_d = rf_rdata1 - immv_d;
            OP_MUL:     alu_d = rf_rdata1 * rf_rdata2;
            OP_DISPLAY: alu_d = rf_rdata1;
            default:    alu_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ir_op_q    <= OP_LOAD;
            ir_dest_q  <= '0;
            ir_sinal_q <= 1'b0;
            ir_imm_q   <= '0;
            clr_idx_q  <= '0;
            raddr1_q   <= '0;
            raddr2_q   <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            lcd_q      <= 1'b0;
            val_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pulse) begin
                        ir_op_q    <= opcode;
                        ir_dest_q  <= dest;
                        ir_sinal_q <= sinalImm;
                        ir_imm_q   <= imm;
                        if (opcode == OP_CLEAR) begin
                            state_q   <= S_CLEAR;
                            clr_idx_q <= '0;
                            we_q      <= 1'b1;
                            waddr_q   <= '0;
                            wdata_q   <= '0;
                        end else begin
                            state_q  <= S_READ;
                            raddr1_q <= src1;
                            raddr2_q <= src2;
                        end
                    end
                end
                S_READ: state_q <= S_EXEC;
                S_EXEC: begin
                    if (ir_op_q == OP_DISPLAY) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                        val_q   <= alu_d;
                        lcd_q   <= 1'b1;
                    end else begin
                        state_q <= S_WRITE;
                        we_q    <= 1'b1;
                        waddr_q <= ir_dest_q;
                        wdata_q <= alu_d;
                    end
                end
                S_WRITE: begin
                    state_q <= S_IDLE;
                    we_q    <= 1'b0;
                    done_q  <= 1'b1;
                    val_q   <= wdata_q;
                    lcd_q   <= 1'b1;
                end
                S_CLEAR: begin
                    if (clr_idx_q == LAST_IDX) begin
                        state_q   <= S_IDLE;
                        clr_idx_q <= '0;
                        we_q      <= 1'b0;
                        done_q    <= 1'b1;
                        val_q     <= '0;
                        lcd_q     <= 1'b0;
                    end else begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                        waddr_q   <= clr_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign rf_raddr1   = raddr1_q;
    assign rf_raddr2   = raddr2_q;
    assign rf_waddr    = waddr_q;
    assign rf_wdata    = wdata_q;
    assign rf_we       = we_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign show_lcd    = lcd_q;
    assign valorFinal  = val_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mini_cpu_control.sv
// Bench for mini_cpu_control: register-file RAM, cycle-indexed expectation model and
// scoreboard of expected writes, driven by directed instruction sequences.
module tb_mini_cpu_control;

    localparam int NCYC = 2048;
    localparam logic [2:0] LOAD = 3'b000, ADD = 3'b001, ADDI = 3'b010, SUB = 3'b011;
    localparam logic [2:0] SUBI = 3'b100, MUL = 3'b101, CLR = 3'b110, DISP = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enviar = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [3:0] src1 = '0, src2 = '0, dest = '0;
    logic sinal_imm = 1'b0;
    logic [5:0] imm = '0;
    logic [15:0] rf_rdata1, rf_rdata2;
    logic [3:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [15:0] rf_wdata, valor_final;
    logic rf_we, busy, done, show_lcd;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    mini_cpu_control dut (
        .clk(clk), .rst(rst), .enviar(enviar), .opcode(opcode),
        .src1(src1), .src2(src2), .dest(dest), .sinalImm(sinal_imm), .imm(imm),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .rf_we(rf_we), .busy(busy), .done(done),
        .show_lcd(show_lcd), .valorFinal(valor_final), .dbg_state_o(dbg_state)
    );

    // Register-file RAM with one-cycle read latency
    logic [15:0] ram [16];
    always @(posedge clk) begin
        if (rf_we) ram[rf_waddr] <= rf_wdata;
        rf_rdata1 <= ram[rf_raddr1];
        rf_rdata2 <= ram[rf_raddr2];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectation model: per-cycle outputs plus an ordered queue of {addr,data} writes
    logic        exp_we [NCYC];
    logic        exp_busy [NCYC];
    logic        exp_done [NCYC];
    logic        exp_lcd [NCYC];
    logic [15:0] exp_val [NCYC];
    logic [19:0] exp_q [$];
    logic [15:0] mregs [16];

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int we_cnt = 0, done_cnt = 0;
    logic [15:0] last_wdata = '0, last_val = '0;
    logic [3:0] last_waddr = '0;
    logic last_lcd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic model_reset(input int k);
        for (int i = k; i < NCYC; i++) begin
            exp_we[i] = 1'b0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
            exp_lcd[i] = 1'b0; exp_val[i] = '0;
        end
        exp_q.delete();
    endtask

    task automatic set_final(input int k, input logic [15:0] v, input logic lcd);
        exp_done[k] = 1'b1;
        for (int i = k; i < NCYC; i++) begin
            exp_val[i] = v;
            exp_lcd[i] = lcd;
        end
    endtask

    // a = index of the first busy cycle (edge that accepts the press)
    task automatic schedule(input int a, input logic [2:0] op, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [3:0] d, input logic sg,
                            input logic [5:0] im);
        logic [15:0] r1, r2, res;
        logic [31:0] prod;
        int iv;
        r1 = mregs[s1];
        r2 = mregs[s2];
        iv = sg ? -int'(im) : int'(im);
        prod = {16'h0000, r1} * {16'h0000, r2};
        res = 16'(iv);
        case (op)
            ADD:  res = r1 + r2;
            ADDI: res = r1 + 16'(iv);
            SUB:  res = r1 - r2;
            SUBI: res = r1 - 16'(iv);
            MUL:  res = prod[15:0];
            default: ;
        endcase
        if (op == CLR) begin
            for (int k = 0; k < 16; k++) begin
                exp_we[a+k] = 1'b1;
                exp_busy[a+k] = 1'b1;
                exp_q.push_back({4'(k), 16'h0000});
                mregs[k] = '0;
            end
            set_final(a + 16, 16'h0000, 1'b0);
        end else if (op == DISP) begin
            exp_busy[a] = 1'b1;
            exp_busy[a+1] = 1'b1;
            set_final(a + 2, r1, 1'b1);
        end else begin
            for (int k = 0; k < 3; k++) exp_busy[a+k] = 1'b1;
            exp_we[a+2] = 1'b1;
            exp_q.push_back({d, res});
            mregs[d] = res;
            set_final(a + 3, res, 1'b1);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc >= NCYC) begin
                chk("cycle_budget", 32'(cyc), 32'(NCYC - 1));
            end else begin
                chk("busy", 32'(busy), 32'(exp_busy[cyc]));
                chk("rf_we", 32'(rf_we), 32'(exp_we[cyc]));
                chk("done", 32'(done), 32'(exp_done[cyc]));
                chk("valorFinal", 32'(valor_final), 32'(exp_val[cyc]));
                chk("show_lcd", 32'(show_lcd), 32'(exp_lcd[cyc]));
                if (rf_we === 1'b1) begin
                    we_cnt++;
                    last_wdata = rf_wdata;
                    last_waddr = rf_waddr;
                    if (exp_q.size() == 0) chk("write_unexpected", {12'h0, rf_waddr, rf_wdata}, 32'hFFFFFFFF);
                    else chk("write_addr_data", {12'h0, rf_waddr, rf_wdata}, {12'h0, exp_q.pop_front()});
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    last_val = valor_final;
                    last_lcd = show_lcd;
                end
            end
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] d, input logic sg, input logic [5:0] im, input int hold);
        @(negedge clk);
        opcode = op; src1 = s1; src2 = s2; dest = d; sinal_imm = sg; imm = im;
        enviar = 1'b1;
        schedule(cyc + 3, op, s1, s2, d, sg, im);
        repeat (4) @(negedge clk);
        enviar = 1'b0;
        repeat (hold) @(negedge clk);
    endtask

    int c, a, wc, dc;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram[i] = '0;
            mregs[i] = '0;
        end
        model_reset(0);
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_raddr1", 32'(rf_raddr1), 32'h0);
        chk("rst_raddr2", 32'(rf_raddr2), 32'h0);
        chk("rst_waddr", 32'(rf_waddr), 32'h0);
        chk("rst_wdata", 32'(rf_wdata), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // LOAD r3 = 5
        do_op(LOAD, 0, 0, 3, 1'b0, 6'd5, 8);
        chk("t1_wdata", 32'(last_wdata), 32'h0005);
        chk("t1_waddr", 32'(last_waddr), 32'h3);
        chk("t1_val", 32'(last_val), 32'h0005);
        chk("t1_lcd", 32'(last_lcd), 32'h1);

        // r1=-7, r2=9, r4=r1+r2 (wraps), r6=r4-(-3)
        do_op(LOAD, 0, 0, 1, 1'b1, 6'd7, 8);
        chk("t2_neg7", 32'(last_wdata), 32'hFFF9);
        do_op(LOAD, 0, 0, 2, 1'b0, 6'd9, 8);
        do_op(ADD, 1, 2, 4, 1'b0, 6'd0, 8);
        chk("t2_add", 32'(last_wdata), 32'h0002);
        do_op(SUBI, 4, 0, 6, 1'b1, 6'd3, 8);
        chk("t2_subi", 32'(last_wdata), 32'h0005);

        // r1 = r2 = 300, MUL -> 90000 mod 2^16
        do_op(LOAD, 0, 0, 7, 1'b0, 6'd60, 8);
        do_op(LOAD, 0, 0, 8, 1'b0, 6'd5, 8);
        do_op(MUL, 7, 8, 1, 1'b0, 6'd0, 8);
        chk("t3_r1_300", 32'(last_wdata), 32'h012C);
        do_op(ADDI, 1, 0, 2, 1'b0, 6'd0, 8);
        do_op(MUL, 1, 2, 5, 1'b0, 6'd0, 8);
        chk("t3_mul_300", 32'(last_wdata), 32'h5F90);
        do_op(LOAD, 0, 0, 7, 1'b0, 6'd16, 8);
        do_op(MUL, 7, 7, 1, 1'b0, 6'd0, 8);
        do_op(MUL, 7, 7, 2, 1'b0, 6'd0, 8);
        do_op(MUL, 1, 2, 5, 1'b0, 6'd0, 8);
        chk("t3_mul_wrap", 32'(last_wdata), 32'h0000);

        // DISPLAY r4: no write, shows 2
        wc = we_cnt;
        do_op(DISP, 4, 0, 0, 1'b0, 6'd0, 8);
        chk("t5_no_write", 32'(we_cnt - wc), 32'h0);
        chk("t5_val", 32'(last_val), 32'h0002);
        chk("t5_lcd", 32'(last_lcd), 32'h1);

        // CLEAR with a second press mid-clear that must be dropped
        wc = we_cnt;
        dc = done_cnt;
        @(negedge clk);
        opcode = CLR;
        enviar = 1'b1;
        schedule(cyc + 3, CLR, 0, 0, 0, 1'b0, 6'd0);
        repeat (4) @(negedge clk);
        enviar = 1'b0;
        repeat (3) @(negedge clk);
        opcode = LOAD; dest = 4'd0; imm = 6'd9;
        enviar = 1'b1;
        repeat (4) @(negedge clk);
        enviar = 1'b0;
        repeat (20) @(negedge clk);
        chk("t4_we_cycles", 32'(we_cnt - wc), 32'd16);
        chk("t4_one_done", 32'(done_cnt - dc), 32'd1);
        chk("t4_val", 32'(last_val), 32'h0000);
        chk("t4_lcd", 32'(last_lcd), 32'h0);
        do_op(DISP, 4, 0, 0, 1'b0, 6'd0, 8);
        chk("t4_r4_cleared", 32'(last_val), 32'h0000);

        // Reset during CLEAR at idx 5 with enviar held through reset
        @(negedge clk);
        opcode = CLR;
        enviar = 1'b1;
        c = cyc;
        a = c + 3;
        schedule(a, CLR, 0, 0, 0, 1'b0, 6'd0);
        repeat (a + 5 - c) @(negedge clk);
        chk("t6_at_idx5", 32'(rf_waddr), 32'h5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset(a + 6);
        @(negedge clk);
        rst = 1'b0;
        dc = done_cnt;
        wc = we_cnt;
        repeat (10) @(negedge clk);
        chk("t6_held_no_done", 32'(done_cnt - dc), 32'h0);
        chk("t6_held_no_write", 32'(we_cnt - wc), 32'h0);
        enviar = 1'b0;
        repeat (5) @(negedge clk);

        // Normal operation resumes after release and new press
        do_op(LOAD, 0, 0, 3, 1'b1, 6'd33, 8);
        do_op(DISP, 3, 0, 0, 1'b0, 6'd0, 8);
        chk("t6_disp_neg33", 32'(last_val), 32'hFFDF);
        do_op(LOAD, 0, 0, 9, 1'b0, 6'd10, 8);
        do_op(SUB, 9, 3, 10, 1'b0, 6'd0, 8);
        chk("sub_neg", 32'(last_wdata), 32'h002B);
        do_op(SUBI, 9, 0, 11, 1'b0, 6'd12, 8);
        chk("subi_pos", 32'(last_wdata), 32'hFFFE);
        do_op(ADDI, 9, 0, 12, 1'b1, 6'd20, 8);
        chk("addi_neg", 32'(last_wdata), 32'hFFF6);

        repeat (3) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
